// File: rtl/pairing_in_loader_if.sv
// Host-to-loader bus for pairing_in_loader: host write beats, run control and the
// shared core-input bus. Master is the host side, slave is the loader.
interface pairing_in_loader_if #(
    parameter int unsigned N_CORES = 7,
    parameter int unsigned HOST_W  = 64,
    parameter int unsigned DATA_W  = 512
);
    logic                wr_valid;
    logic                wr_ready;
    logic [12:0]         wr_addr;
    logic [HOST_W-1:0]   wr_data;
    logic                start;
    logic [3:0]          func_in;
    logic [N_CORES-1:0]  extin_en;
    logic [7:0]          extin_addr;
    logic [DATA_W-1:0]   extin_data;
    logic                run;
    logic [3:0]          n_func;
    logic                busy;
    logic                err_addr;

    modport master (
        output wr_valid, wr_addr, wr_data, start, func_in,
        input  wr_ready, extin_en, extin_addr, extin_data, run, n_func, busy, err_addr
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, start, func_in,
        output wr_ready, extin_en, extin_addr, extin_data, run, n_func, busy, err_addr
    );
endinterface

// File: rtl/pairing_in_loader.sv
// Assembles HOST_W-bit host beats into DATA_W-bit words, strobes them into one of
// N_CORES pairing cores, and issues a run pulse once all loaded words are delivered.
// Optional macro LOADER_BROADCAST_EN: core index 5'h1F writes all cores at once.
module pairing_in_loader #(
    parameter int unsigned N_CORES = 7,
    parameter int unsigned HOST_W  = 64,
    parameter int unsigned DATA_W  = 512
) (
    input logic             clk,
    input logic             CPU_RESET,
    pairing_in_loader_if.slave bus
);
    localparam int unsigned BEATS = DATA_W / HOST_W;
    localparam int unsigned BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StRun} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [BW-1:0]       r_beat;
    logic [DATA_W-1:0]   r_asm;
    logic [4:0]          r_core;
    logic [7:0]          r_waddr;
    logic [N_CORES-1:0]  r_en;
    logic [7:0]          r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_func;
    logic                r_err;

    logic                w_beat_acc;
    logic                w_last;
    logic                w_word_done;
    logic                w_start_acc;
    logic                w_core_legal;
    logic                w_bcast;
    logic [N_CORES-1:0]  w_mask;
    logic [DATA_W-1:0]   w_word;

    assign w_beat_acc  = bus.wr_valid && (r_state == StIdle);
    assign w_last      = (r_beat == LastBeat);
    assign w_word_done = w_beat_acc && w_last;
    // With BEATS >= 2 a same-cycle beat only leaves the counter at 0 if it is the last one
    assign w_start_acc = (r_state == StIdle) && bus.start &&
                         (w_beat_acc ? w_last : (r_beat == '0));

    // r_core was latched on beat 0, which always precedes the final beat
    assign w_core_legal = (32'(r_core) < N_CORES);
`ifdef LOADER_BROADCAST_EN
    assign w_bcast = (r_core == 5'h1F);
`else
    assign w_bcast = 1'b0;
`endif

    // Strobe pattern and assembled word for the beat being accepted
    always_comb begin
        w_mask = '0;
        if (w_core_legal) begin
            w_mask = N_CORES'(1) << r_core;
        end else if (w_bcast) begin
            w_mask = '1;
        end
        w_word = r_asm;
        w_word[r_beat*HOST_W +: HOST_W] = bus.wr_data;
    end

    // Next-state logic for the start/drain/run sequence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start_acc) w_state_next = StDrain;
            StDrain: if (r_en == '0) w_state_next = StRun;
            StRun:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Beat assembly, core strobe, function code and sticky error
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            r_beat  <= '0;
            r_asm   <= '0;
            r_core  <= '0;
            r_waddr <= '0;
            r_en    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_func  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_en <= '0;
            if (w_beat_acc) begin
                r_asm  <= w_word;
                r_beat <= w_last ? '0 : r_beat + 1'b1;
                if (r_beat == '0) begin
                    r_core  <= bus.wr_addr[12:8];
                    r_waddr <= bus.wr_addr[7:0];
                end
            end
            if (w_word_done) begin
                r_data <= w_word;
                r_addr <= r_waddr;
                r_en   <= w_mask;
                if (!w_core_legal && !w_bcast) begin
                    r_err <= 1'b1;
                end
            end
            if (w_start_acc) begin
                r_func <= bus.func_in;
            end
        end
    end

    assign bus.wr_ready   = (r_state == StIdle);
    assign bus.run        = (r_state == StRun);
    assign bus.busy       = (r_state != StIdle) || (r_beat != '0);
    assign bus.extin_en   = r_en;
    assign bus.extin_addr = r_addr;
    assign bus.extin_data = r_data;
    assign bus.n_func     = r_func;
    assign bus.err_addr   = r_err;
endmodule

// File: tb/tb_pairing_in_loader.sv
// Self-checking bench for pairing_in_loader: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a word-level model.
module tb_pairing_in_loader;
    localparam int unsigned NC = 7;
    localparam int unsigned HW = 64;
    localparam int unsigned DW = 512;
    localparam int NB = 8;

    logic clk;
    logic CPU_RESET;
    int   checks;
    int   failures;

    pairing_in_loader_if #(.N_CORES(NC), .HOST_W(HW), .DATA_W(DW)) bus ();

    pairing_in_loader #(.N_CORES(NC), .HOST_W(HW), .DATA_W(DW)) dut (
        .clk       (clk),
        .CPU_RESET (CPU_RESET),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: spec-level view of loader (mode 0 idle, 1 drain, 2 run)
    bit          m_live;
    int          m_mode;
    int          m_nb;
    logic [63:0] m_beats [NB];
    logic [4:0]  m_core;
    logic [7:0]  m_waddr;
    logic [6:0]  m_en;
    logic [7:0]  m_addr;
    logic [511:0] m_data;
    logic [3:0]  m_func;
    logic        m_err;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [6:0] en_prev;
        int old_mode;
        if (CPU_RESET) begin
            m_live = 1'b1;
            m_mode = 0;
            m_nb   = 0;
            m_en   = '0;
            m_addr = '0;
            m_data = '0;
            m_func = '0;
            m_err  = 1'b0;
        end else if (m_live) begin
            en_prev  = m_en;
            m_en     = '0;
            old_mode = m_mode;
            if (old_mode == 0 && bus.wr_valid) begin
                if (m_nb == 0) begin
                    m_core  = bus.wr_addr[12:8];
                    m_waddr = bus.wr_addr[7:0];
                end
                m_beats[m_nb] = bus.wr_data;
                m_nb++;
                if (m_nb == NB) begin
                    m_data = '0;
                    for (int b = 0; b < NB; b++)
                        m_data = m_data | ({448'd0, m_beats[b]} << (64 * b));
                    m_addr = m_waddr;
                    if (int'(m_core) < NC) m_en = 7'd1 << m_core;
`ifdef LOADER_BROADCAST_EN
                    else if (m_core == 5'd31) m_en = 7'h7F;
`endif
                    else m_err = 1'b1;
                    m_nb = 0;
                end
            end
            case (old_mode)
                0: if (bus.start && m_nb == 0) begin
                    m_mode = 1;
                    m_func = bus.func_in;
                end
                1: if (en_prev == 0) m_mode = 2;
                default: m_mode = 0;
            endcase
        end
    endtask

    // Compare process: outputs vs model at every negedge, then advance the model with
    // the inputs that the coming rising edge will sample.
    initial begin
        m_live = 1'b0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("wr_ready", 512'(bus.wr_ready), 512'(m_mode == 0));
                chk("run", 512'(bus.run), 512'(m_mode == 2));
                chk("busy", 512'(bus.busy), 512'(m_mode != 0 || m_nb != 0));
                chk("extin_en", 512'(bus.extin_en), 512'(m_en));
                chk("extin_addr", 512'(bus.extin_addr), 512'(m_addr));
                chk("extin_data", bus.extin_data, m_data);
                chk("n_func", 512'(bus.n_func), 512'(m_func));
                chk("err_addr", 512'(bus.err_addr), 512'(m_err));
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        CPU_RESET = 1'b1;
        tick();
        tick();
        CPU_RESET = 1'b0;
    endtask

    task automatic send_beat(input logic [12:0] a, input logic [63:0] d, input logic st);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.start    = st;
        tick();
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    initial begin
        logic [511:0] exp1;
        logic [511:0] d;
        logic [4:0]   core;
        checks       = 0;
        failures     = 0;
        CPU_RESET    = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.func_in  = '0;
        do_reset();
        chk("rst_ready", 512'(bus.wr_ready), 512'(1));
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_en", 512'(bus.extin_en), 512'(0));
        chk("rst_data", bus.extin_data, 512'(0));
        chk("rst_nfunc", 512'(bus.n_func), 512'(0));
        chk("rst_err", 512'(bus.err_addr), 512'(0));

        // Word to core 2, address 5
        exp1 = {64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1, 64'd0};
        for (int b = 0; b < NB; b++) send_beat(13'h0205, 64'(b), 1'b0);
        chk("w1_en", 512'(bus.extin_en), 512'(7'b0000100));
        chk("w1_addr", 512'(bus.extin_addr), 512'(8'h05));
        chk("w1_data", bus.extin_data, exp1);
        tick();
        chk("w1_en_off", 512'(bus.extin_en), 512'(0));
        chk("w1_data_hold", bus.extin_data, exp1);

        // Start after a completed word
        bus.start   = 1'b1;
        bus.func_in = 4'h3;
        tick();
        bus.start = 1'b0;
        chk("s_ready", 512'(bus.wr_ready), 512'(0));
        chk("s_run0", 512'(bus.run), 512'(0));
        chk("s_nfunc", 512'(bus.n_func), 512'(4'h3));
        tick();
        chk("s_run1", 512'(bus.run), 512'(1));
        tick();
        chk("s_run2", 512'(bus.run), 512'(0));
        chk("s_busy", 512'(bus.busy), 512'(0));
        chk("s_ready2", 512'(bus.wr_ready), 512'(1));

        // Start mid-word is ignored
        for (int b = 0; b < 3; b++) send_beat(13'h0312, 64'h30 + 64'(b), 1'b0);
        bus.start   = 1'b1;
        bus.func_in = 4'h5;
        tick();
        bus.start = 1'b0;
        chk("mid_ready", 512'(bus.wr_ready), 512'(1));
        chk("mid_busy", 512'(bus.busy), 512'(1));
        for (int b = 3; b < NB; b++) send_beat(13'h0312, 64'h30 + 64'(b), 1'b0);
        chk("mid_en", 512'(bus.extin_en), 512'(7'b0001000));
        chk("mid_addr", 512'(bus.extin_addr), 512'(8'h12));
        tick();
        tick();
        chk("mid_norun", 512'(bus.run), 512'(0));
        chk("mid_nfunc", 512'(bus.n_func), 512'(4'h3));

        // Illegal core index
        for (int b = 0; b < NB; b++) send_beat(13'h0901, 64'(b), 1'b0);
        chk("ill_en", 512'(bus.extin_en), 512'(0));
        chk("ill_err", 512'(bus.err_addr), 512'(1));
        tick();
        chk("ill_err_sticky", 512'(bus.err_addr), 512'(1));
        do_reset();
        chk("ill_err_rst", 512'(bus.err_addr), 512'(0));

        // Core index 31
        for (int b = 0; b < NB; b++) send_beat(13'h1F10, 64'(b), 1'b0);
`ifdef LOADER_BROADCAST_EN
        chk("bc_en", 512'(bus.extin_en), 512'(7'b1111111));
        chk("bc_err", 512'(bus.err_addr), 512'(0));
`else
        chk("bc_en", 512'(bus.extin_en), 512'(0));
        chk("bc_err", 512'(bus.err_addr), 512'(1));
`endif
        do_reset();

        // Reset mid-word, then fresh word with start on its last beat, then reset in drain
        for (int b = 0; b < 5; b++) send_beat(13'h0100, 64'hAAAA_0000 + 64'(b), 1'b0);
        CPU_RESET = 1'b1;
        tick();
        CPU_RESET = 1'b0;
        chk("rm_busy", 512'(bus.busy), 512'(0));
        tick();
        chk("rm_en", 512'(bus.extin_en), 512'(0));
        bus.func_in = 4'h9;
        for (int b = 0; b < NB; b++) send_beat(13'h0603, 64'h10 + 64'(b), b == NB - 1);
        d = bus.extin_data;
        chk("fw_en", 512'(bus.extin_en), 512'(7'b1000000));
        chk("fw_addr", 512'(bus.extin_addr), 512'(8'h03));
        chk("fw_lo", 512'(d[63:0]), 512'(64'h10));
        chk("fw_hi", 512'(d[511:448]), 512'(64'h17));
        chk("fw_drain", 512'(bus.wr_ready), 512'(0));
        CPU_RESET = 1'b1;
        tick();
        CPU_RESET = 1'b0;
        chk("rd_ready", 512'(bus.wr_ready), 512'(1));
        chk("rd_en", 512'(bus.extin_en), 512'(0));
        for (int i = 0; i < 3; i++) begin
            chk("rd_norun", 512'(bus.run), 512'(0));
            tick();
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.wr_valid = ($urandom_range(9) < 7);
            if ($urandom_range(7) < 6) core = 5'($urandom_range(NC - 1));
            else if ($urandom_range(1) == 1) core = 5'd31;
            else core = 5'($urandom_range(30, NC));
            bus.wr_addr  = {core, 8'($urandom)};
            bus.wr_data  = {$urandom, $urandom};
            bus.start    = ($urandom_range(7) == 0);
            bus.func_in  = 4'($urandom);
            CPU_RESET    = ($urandom_range(299) == 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        CPU_RESET    = 1'b0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
